// File: rtl/mdu_hilo.sv
// MIPS EX-stage multiply/divide unit with architectural HI/LO registers.
// Operands are latched at start, the result is formed from the latched copy during RUN and committed on the last busy edge.
module mdu_hilo (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [3:0] MULT_LAT = 4'd5;
    localparam logic [3:0] DIV_LAT  = 4'd10;

    state_e      state;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        load_op;
    logic        write_hi_a;
    logic        write_lo_a;
    logic        commit;

    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_ok;

    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] div_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] calc_hi;
    logic [31:0] calc_lo;
    logic        calc_ok;

    assign state = (cnt != 4'd0) ? RUN : IDLE;
    assign busy  = (cnt != 4'd0);

    // Next-state and control decode; starts are only honoured in IDLE.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
        cnt_next   = cnt;
        load_op    = 1'b0;
        write_hi_a = 1'b0;
        write_lo_a = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    case (md_op_e'(md_op))
                        OP_MULT, OP_MULTU: begin
                            cnt_next = MULT_LAT;
                            load_op  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            cnt_next = DIV_LAT;
                            load_op  = 1'b1;
                        end
                        OP_MTHI: write_hi_a = 1'b1;
                        OP_MTLO: write_lo_a = 1'b1;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_next = cnt - 4'd1;
                commit   = (cnt == 4'd1);
            end
        endcase
    end

    // Signed divide works on magnitudes, so MIN_INT / -1 wraps to 0x80000000 without overflow.
    always_comb begin
        is_signed = (op_q == OP_DIV);
        mag_a     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
        mag_b     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
        div_b     = (b_q == 32'd0) ? 32'd1 : mag_b;
        quo_u     = mag_a / div_b;
        rem_u     = mag_a % div_b;
        prod_u    = {32'd0, a_q} * {32'd0, b_q};
        prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

        calc_hi = res_hi;
        calc_lo = res_lo;
        calc_ok = 1'b0;
        case (op_q)
            OP_MULT: begin
                {calc_hi, calc_lo} = prod_s;
                calc_ok            = 1'b1;
            end
            OP_MULTU: begin
                {calc_hi, calc_lo} = prod_u;
                calc_ok            = 1'b1;
            end
            OP_DIV: begin
                calc_lo = (a_q[31] ^ b_q[31]) ? (~quo_u + 32'd1) : quo_u;
                calc_hi = a_q[31] ? (~rem_u + 32'd1) : rem_u;
                calc_ok = (b_q != 32'd0);
            end
            OP_DIVU: begin
                calc_lo = quo_u;
                calc_hi = rem_u;
                calc_ok = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: HI/LO and the datapath registers are reset too, so an aborted op can never leak a result.
            cnt    <= 4'd0;
            op_q   <= OP_NOP;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_ok <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
            cnt <= cnt_next;
            if (load_op) begin
                op_q <= md_op_e'(md_op);
                a_q  <= a;
                b_q  <= b;
            end
            if (state == RUN) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                res_ok <= calc_ok;
            end
            // Commit uses the result registered on an earlier RUN edge; a divide by zero leaves HI/LO alone.
            if (commit && res_ok) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (write_hi_a) hi <= a;
            if (write_lo_a) lo <= a;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: behavioural HI/LO model compared every cycle, plus literal pins.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    int dut_viol = 0;

    // Behavioural model: architectural HI/LO, remaining busy cycles and the pending result.
    int          busy_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    bit          p_ok = 1'b0;

    mdu_hilo dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .md_op  (md_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        p_hi = 32'd0;
        p_lo = 32'd0;
        p_ok = 1'b0;
    endtask

    task automatic model_step();
        longint      sa;
        longint      sb;
        longint      sq;
        longint      sr;
        logic [63:0] pv;
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0 && p_ok) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start) begin
            case (md_op)
                3'd1: begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    pv = 64'(sa * sb);
                    {p_hi, p_lo} = pv;
                    p_ok = 1'b1;
                    busy_left = 5;
                end
                3'd2: begin
                    pv = 64'(a) * 64'(b);
                    {p_hi, p_lo} = pv;
                    p_ok = 1'b1;
                    busy_left = 5;
                end
                3'd3: begin
                    p_ok = (b != 32'd0);
                    if (p_ok) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                        sq = sa / sb;
                        sr = sa % sb;
                        pv = 64'(sq);
                        p_lo = pv[31:0];
                        pv = 64'(sr);
                        p_hi = pv[31:0];
                    end
                    busy_left = 10;
                end
                3'd4: begin
                    p_ok = (b != 32'd0);
                    if (p_ok) begin
                        p_lo = a / b;
                        p_hi = a % b;
                    end
                    busy_left = 10;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive inputs, let DUT and model see the same edge, then release start.
    task automatic cyc(input bit s, input logic [2:0] op, input logic [31:0] aa, input logic [31:0] bb);
        start = s;
        md_op = op;
        a     = aa;
        b     = bb;
        if (s && busy) dut_viol++;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_step();
        #1;
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 32'd0, 32'd0);
    endtask

    // Counts busy-high cycles from just after a start edge; bounded so a stuck busy cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy) n++;
            cyc(1'b0, 3'd0, 32'd0, 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, busy_left != 0});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    end

    initial begin
        int n;
        int v0;
        #1;
        idle(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Reset in the middle of a MULT discards it.
        cyc(1'b1, 3'd5, 32'h55, 32'd0);
        cyc(1'b1, 3'd6, 32'h66, 32'd0);
        cyc(1'b1, 3'd1, 32'd3, 32'd4);
        idle(2);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        #3;
        idle(1);
        reset_n = 1'b1;
        idle(4);
        check("postrst_hi", hi, 32'd0);
        check("postrst_lo", lo, 32'd0);

        cyc(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2);
        count_busy(n);
        check("mult_busy", 32'(n), 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);

        cyc(1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2);
        count_busy(n);
        check("multu_busy", 32'(n), 32'd5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);

        cyc(1'b1, 3'd3, 32'hFFFF_FFF9, 32'h2);
        count_busy(n);
        check("div_busy", 32'(n), 32'd10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        cyc(1'b1, 3'd4, 32'd7, 32'd2);
        count_busy(n);
        check("divu_busy", 32'(n), 32'd10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        cyc(1'b1, 3'd5, 32'h11, 32'd0);
        cyc(1'b1, 3'd6, 32'h22, 32'd0);
        cyc(1'b1, 3'd4, 32'd5, 32'd0);
        count_busy(n);
        check("div0_busy", 32'(n), 32'd10);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        cyc(1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        cyc(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        cyc(1'b1, 3'd6, 32'h1234_5678, 32'd0);
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi", hi, 32'hDEAD_BEEF);
        check("mtlo_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: a new op issued in the first cycle busy is low.
        cyc(1'b1, 3'd4, 32'd100, 32'd7);
        idle(10);
        check("b2b_busy_low", {31'd0, busy}, 32'd0);
        check("b2b_lo", lo, 32'd14);
        check("b2b_hi", hi, 32'd2);
        cyc(1'b1, 3'd2, 32'h0001_0000, 32'h0001_0000);
        check("b2b_accept", {31'd0, busy}, 32'd1);
        check("b2b_hold_lo", lo, 32'd14);
        count_busy(n);
        check("b2b_mul_busy", 32'(n), 32'd5);
        check("b2b_mul_hi", hi, 32'd1);
        check("b2b_mul_lo", lo, 32'd0);

        // Starts issued while busy (protocol violations) must be ignored, MTLO included.
        cyc(1'b1, 3'd5, 32'hAAAA, 32'd0);
        v0 = dut_viol;
        cyc(1'b1, 3'd1, 32'd2, 32'd3);
        cyc(1'b1, 3'd1, 32'd2, 32'd3);
        cyc(1'b1, 3'd6, 32'h99, 32'd0);
        cyc(1'b1, 3'd1, 32'd2, 32'd3);
        idle(1);
        cyc(1'b1, 3'd1, 32'd2, 32'd3);
        check("viol_count", 32'(dut_viol - v0), 32'd4);
        check("viol_busy", {31'd0, busy}, 32'd0);
        check("viol_hi", hi, 32'd0);
        check("viol_lo", lo, 32'd6);
        cyc(1'b1, 3'd6, 32'h77, 32'd0);
        check("mtlo_after_lo", lo, 32'h77);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = pick();
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : pick();
            cyc($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), ra, rb);
            idle($urandom_range(0, 12));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multiply/divide unit with HI/LO registers for the EX stage of the five-stage MIPS pipeline. Consumes the decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO operations and forwarded operands from the EX stage. It runs multi-cycle operations behind a busy flag and exposes HI/LO to the MFHI/MFLO datapath. The hazard unit stalls on `busy | start` to keep dependent instructions out of EX.

## Interface
- No parameters. Latencies are fixed: MULT_LAT = 5, DIV_LAT = 10.
- clk  in  1  rising-edge clock, the single clock shared with the pipeline.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  EX-stage instruction is an MDU op. Qualifies md_op. May be high only when the instruction is valid and not stalled.
- md_op  in  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO. Codes 0 and 7 are no-ops.
- a  in  32  rs operand, after forwarding.
- b  in  32  rt operand, after forwarding.
- busy  out  1  a multi-cycle operation is in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- States: IDLE and RUN. The state is a 4-bit down-counter `cnt`; RUN when cnt != 0. busy = (cnt != 0), driven straight from the register.
- IDLE with start and md_op in 1..4:
  - Latch the op, a and b.
  - Load cnt with 5 for multiplies, 10 for divides.
  - Compute the result into internal res_hi/res_lo. Either a single-cycle computation registered at start, or an iterative one; both are legal if the timing below holds.
- RUN: cnt decrements every cycle. On the edge where cnt goes 1 -> 0, hi <= res_hi and lo <= res_lo.
- MTHI/MTLO in IDLE: hi <= a (MTHI) or lo <= a (MTLO) at that edge. busy stays low.
- Arithmetic:
  - MULT: {hi,lo} = signed a × signed b, 64-bit.
  - MULTU: {hi,lo} = unsigned a × unsigned b, 64-bit.
  - DIV: lo = quotient, truncated toward zero; hi = remainder, sign of the dividend a.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000.
  - Divide by zero (b == 0): busy runs the full 10 cycles and hi/lo are left unchanged.
- start while busy: protocol violation, because the hazard unit must prevent it. The RTL ignores it: no state change, and hi/lo are not written, including by MTHI/MTLO. The bench flags it with an assertion.
- Codes 0 and 7, and start low: no effect.
- Reset (asynchronous, any time, including mid-RUN): cnt = 0, busy = 0, hi = 0, lo = 0, internal result and operand registers = 0. The in-flight operation is discarded, with no write at release.

## Timing
- Start sampled at edge E0.
- Multiply: busy is high in cycles E0+1 .. E0+5. New hi/lo are visible, and busy is low, from E0+5's edge onward. That is 5 cycles of stall for a dependent MFHI/MFLO or MDU op, given the hazard unit also stalls on start in E0's cycle.
- Divide: the same pattern with 10 busy cycles.
- A back-to-back start in the first cycle busy is low is accepted. The final-write edge and the new-start edge coincide, and the new op's latch does not disturb the hi/lo write.
- MTHI/MTLO: new value visible the cycle after E0. Zero added latency.
- hi/lo are combinational-free register outputs, safe for the forwarding mux.
- Between writes, hi/lo hold the old values while busy is high. Readers must stall and not sample them.

## Test plan
- Reset mid-RUN: start MULT 3 × 4. Pulse reset_n low at E0+2 -> busy = 0 at once and hi = lo = 0. After release, no write occurs at E0+5.
- MULT 0xFFFFFFFF × 0x00000002 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFFE. MULTU with the same operands -> hi = 0x00000001, lo = 0xFFFFFFFE. busy is high exactly 5 cycles each.
- DIV 0xFFFFFFF9 (−7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 2 -> lo = 3, hi = 1. busy is high exactly 10 cycles.
- Prior hi = 0x11, lo = 0x22. DIVU 5 / 0 -> busy 10 cycles, then hi = 0x11, lo = 0x22. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI 0xDEADBEEF, next cycle MTLO 0x12345678 -> hi and lo are updated one cycle after each start. busy never asserts.
- MULT 2 × 3 started with start held during busy, and with an MTLO 0x99 in cycle E0+2 -> both extra starts are ignored. Result hi = 0, lo = 6. An MTLO issued the first cycle busy is low is accepted.
